// File: rtl/layer_0_input_streamer_if.sv
// Handshake and memory bus bundle for the layer-0 input streamer.
// master = streamer side, slave = frame controller / memory / consumer side.
interface layer_0_input_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20
);
    logic                      start;
    logic                      hold;
    logic                      mem_rd_en;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_rd_data;
    logic [3*DATA_WIDTH-1:0]   data_out;
    logic                      valid_out;
    logic                      last_out;
    logic                      busy;
    logic                      done;

    modport master (
        input  start, hold, mem_rd_data,
        output mem_rd_en, mem_addr, data_out, valid_out, last_out, busy, done
    );

    modport slave (
        output start, hold, mem_rd_data,
        input  mem_rd_en, mem_addr, data_out, valid_out, last_out, busy, done
    );
endinterface

// File: rtl/layer_0_input_streamer.sv
// Layer-0 input streamer: reads a channel-interleaved raster image from a
// word memory (address = 3*(row*IMG_SIZE+col)+ch) and emits one packed
// 3-channel pixel per valid_out pulse. Memory read latency is one cycle.
module layer_0_input_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 416,
    parameter int ADDR_WIDTH = 20
) (
    input  logic Clk,
    input  logic Rst,
    layer_0_input_streamer_if.master bus
);

    localparam int unsigned NUM_WORDS = 3 * IMG_SIZE * IMG_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state_r;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic [1:0]                ch_r;
    logic [DATA_WIDTH-1:0]     slot0_r;
    logic [DATA_WIDTH-1:0]     slot1_r;
    logic                      rd_pend_r;   // a read was issued last cycle
    logic                      rd_last_r;   // ... and it was the final word of the frame
    logic [3*DATA_WIDTH-1:0]   data_out_r;
    logic                      valid_r;
    logic                      last_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      issue_s;

    // A read goes out every READ cycle unless the consumer is holding us off.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == READ) && !bus.hold) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Frame FSM, address counter, channel capture and registered pixel output.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            ch_r       <= 2'd0;
            slot0_r    <= '0;
            slot1_r    <= '0;
            rd_pend_r  <= 1'b0;
            rd_last_r  <= 1'b0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_pend_r <= issue_s;
            rd_last_r <= issue_s && (addr_r == LAST_ADDR);

            // Returned words land in the slot of their channel; ch2 completes a pixel.
            if (rd_pend_r) begin
                case (ch_r)
                    2'd0: begin
                        slot0_r <= bus.mem_rd_data;
                        ch_r    <= 2'd1;
                    end
                    2'd1: begin
                        slot1_r <= bus.mem_rd_data;
                        ch_r    <= 2'd2;
                    end
                    2'd2: begin
                        data_out_r <= {bus.mem_rd_data, slot1_r, slot0_r};
                        valid_r    <= 1'b1;
                        last_r     <= rd_last_r;
                        ch_r       <= 2'd0;
                    end
                    default: begin
                        ch_r <= 2'd0;
                    end
                endcase
            end

            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r <= READ;
                        busy_r  <= 1'b1;
                        addr_r  <= '0;
                        ch_r    <= 2'd0;
                    end
                end
                READ: begin
                    // The counter parks on the final address rather than running past it.
                    if (issue_s) begin
                        if (addr_r == LAST_ADDR) begin
                            state_r <= DRAIN;
                        end else begin
                            addr_r <= addr_r + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Leave once the final pixel has been presented.
                    if (valid_r && last_r) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = issue_s;
    assign bus.mem_addr  = addr_r;
    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_r;
    assign bus.last_out  = last_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_layer_0_input_streamer.sv
// Bench for layer_0_input_streamer with IMG_SIZE=4 and memory word a = a.
module tb_layer_0_input_streamer;

    localparam int DW   = 32;
    localparam int AW   = 6;
    localparam int IMG  = 4;
    localparam int NPIX = IMG * IMG;

    logic Clk;
    logic Rst;

    layer_0_input_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    layer_0_input_streamer #(
        .DATA_WIDTH(DW),
        .IMG_SIZE  (IMG),
        .ADDR_WIDTH(AW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [3*DW-1:0] data;
        logic            last;
    } pix_t;

    typedef struct {
        int hs;
        int he;
        int mid;
        int exp_first_issue;
        int exp_first;
        int exp_last_issue;
        int exp_done;
    } row_t;

    pix_t            sb[$];
    row_t            rows[5];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              start_cyc = 0;
    int              exp_addr, n_valid, n_last, n_done;
    int              first_valid, last_valid, first_issue, last_issue, done_rel;
    int              rel_m;
    logic [3*DW-1:0] held = '0;

    always #5 Clk = ~Clk;

    // Cycle counter used for frame-relative timing.
    always @(posedge Clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency, word a holds value a.
    always @(posedge Clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= DW'(bus.mem_addr);
    end

    task automatic chk(input string nm, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: address sequence, scoreboard pops, hold-between-pixels, done.
    always @(negedge Clk) begin
        if (!Rst) begin
            rel_m = cyc - start_cyc;
            if (bus.mem_rd_en) begin
                chk("rd_addr", 96'(bus.mem_addr), 96'(exp_addr));
                chk("rd_while_hold", 96'(bus.hold), 96'(0));
                if (first_issue < 0) first_issue = rel_m;
                last_issue = rel_m;
                exp_addr++;
            end
            if (bus.valid_out) begin
                n_valid++;
                if (first_valid < 0) first_valid = rel_m;
                last_valid = rel_m;
                if (bus.last_out) n_last++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got data %0h with no pixel expected", bus.data_out);
                end else begin
                    pix_t e;
                    e = sb.pop_front();
                    chk("pixel_data", bus.data_out, e.data);
                    chk("pixel_last", 96'(bus.last_out), 96'(e.last));
                end
                held = bus.data_out;
            end else begin
                chk("last_without_valid", 96'(bus.last_out), 96'(0));
                chk("data_held", bus.data_out, held);
            end
            if (bus.done) begin
                n_done++;
                done_rel = rel_m;
                chk("busy_at_done", 96'(bus.busy), 96'(0));
            end
        end
    end

    function automatic bit hold_for(input int rel, input int hs, input int he, input bit rnd);
        if (rnd) return 1'($urandom_range(0, 1));
        return (rel >= hs) && (rel <= he);
    endfunction

    // Called just after a rising edge: this cycle becomes frame cycle 0.
    task automatic frame_begin();
        n_valid = 0; n_last = 0; n_done = 0; exp_addr = 0;
        first_valid = -1; last_valid = -1; first_issue = -1; last_issue = -1; done_rel = -1;
        for (int p = 0; p < NPIX; p++) begin
            pix_t e;
            e.data = {DW'(3 * p + 2), DW'(3 * p + 1), DW'(3 * p)};
            e.last = (p == NPIX - 1);
            sb.push_back(e);
        end
        start_cyc = cyc;
        bus.start = 1'b1;
    endtask

    task automatic run_frame(input row_t r, input bit rnd);
        int rel;
        bit seen;
        frame_begin();
        bus.hold = hold_for(0, r.hs, r.he, rnd);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge Clk);
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                @(posedge Clk); #1;
                rel = cyc - start_cyc;
                bus.start = (rel == r.mid);
                bus.hold  = hold_for(rel, r.hs, r.he, rnd);
            end
        end
        #1;
        chk("done_seen", 96'(seen), 96'(1));
        chk("valid_count", 96'(n_valid), 96'(NPIX));
        chk("last_count", 96'(n_last), 96'(1));
        chk("done_count", 96'(n_done), 96'(1));
        chk("sb_empty", 96'(sb.size()), 96'(0));
        chk("done_after_last", 96'(done_rel), 96'(last_valid + 1));
        chk("issue_count", 96'(exp_addr), 96'(3 * NPIX));
        if (!rnd) begin
            chk("first_issue_cycle", 96'(first_issue), 96'(r.exp_first_issue));
            chk("first_valid_cycle", 96'(first_valid), 96'(r.exp_first));
            chk("last_issue_cycle", 96'(last_issue), 96'(r.exp_last_issue));
            chk("done_cycle", 96'(done_rel), 96'(r.exp_done));
        end
        @(posedge Clk); #1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        chk("idle_after_done", 96'({bus.busy, bus.done}), 96'(0));
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, 96'({bus.mem_rd_en, bus.mem_addr, bus.valid_out, bus.last_out, bus.busy, bus.done}), 96'(0));
        chk({nm, "_data"}, bus.data_out, 96'(0));
    endtask

    initial begin
        row_t norm;
        //          hs  he  mid fi  fv  li  done
        rows[0] = '{-1, -1, -1, 1,  5,  48, 51};
        rows[1] = '{ 2,  4, -1, 1,  8,  51, 54};
        rows[2] = '{ 1,  1, -1, 2,  6,  49, 52};
        rows[3] = '{ 3,  3, -1, 1,  6,  49, 52};
        rows[4] = '{-1, -1, 10, 1,  5,  48, 51};
        norm = rows[0];

        Clk = 1'b0;
        Rst = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.mem_rd_data = '0;
        @(negedge Clk);
        chk_all_zero("reset_state");
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Table rows run back-to-back: each start lands in the cycle after done.
        for (int i = 0; i < 5; i++) run_frame(rows[i], 1'b0);

        // Random hold at 50% density.
        run_frame(norm, 1'b1);

        // Reset in frame cycle 20 aborts the frame.
        frame_begin();
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk); #1;
            bus.start = 1'b0;
        end
        Rst = 1'b1;
        held = '0;
        sb.delete();
        #1;
        chk_all_zero("abort_reset");
        @(negedge Clk);
        chk_all_zero("abort_reset_hold");
        @(posedge Clk); #1;
        Rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            chk("quiet_after_reset", 96'({bus.valid_out, bus.done, bus.busy, bus.mem_rd_en}), 96'(0));
        end
        @(posedge Clk); #1;
        run_frame(norm, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
